cache_ctrl_fsm: RTL and testbench

Sequencing controller in front of one direct-indexed cache array: combinational lookup, synchronous line write with tag/valid/data per line. Accepts one CPU request at a time over a valid/ready handshake and runs the lookup. Refills from memory on a read miss and writes through to memory on every store. Also sweeps all lines invalid on reset and on flush request.

---
 rtl/cache_ctrl_fsm.sv | 147 ++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a direct-indexed, write-through, write-allocate cache.
// Serves one CPU request at a time, refills on load misses and sweeps the array on reset/flush.
module cache_ctrl_fsm #(
  parameter int SET_BIT_WIDTH = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  cache_write,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_valid_in,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic [2:0]            fsm_state
);

  localparam logic [2:0] FLUSH    = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] LOOKUP   = 3'd2;
  localparam logic [2:0] MEM_REQ  = 3'd3;
  localparam logic [2:0] MEM_WAIT = 3'd4;
  localparam logic [2:0] FILL     = 3'd5;
  localparam logic [2:0] RESP     = 3'd6;

  localparam logic [SET_BIT_WIDTH-1:0] LAST_SET = '1;

  logic [2:0]               state;
  logic [SET_BIT_WIDTH-1:0] sweep_cnt;
  logic                     pending_flush;
  logic                     req_write;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [DATA_WIDTH-1:0]    resp_data;
  logic [DATA_WIDTH-1:0]    last_rdata;
  logic                     accept;

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; the requester holds its payload stable until then. Responses
  // (cpu_resp_valid, mem_resp_valid) are single-cycle pulses without backpressure.
  assign cpu_req_ready = (state == IDLE) && !flush_req && !pending_flush;
  assign accept        = cpu_req_valid && cpu_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FLUSH;
      sweep_cnt     <= '0;
      pending_flush <= 1'b0;
      req_write     <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      resp_data     <= '0;
      last_rdata    <= '0;
    end else begin
      case (state)
        FLUSH: begin
          if (sweep_cnt == LAST_SET) begin
            sweep_cnt <= '0;
            state     <= IDLE;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (flush_req || pending_flush) begin
            pending_flush <= 1'b0;
            state         <= FLUSH;
          end else if (accept) begin
            req_write <= cpu_req_write;
            req_addr  <= cpu_req_addr;
            req_wdata <= cpu_req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req_write && cache_hit) begin
            resp_data <= cache_rdata;
            state     <= RESP;
          end else begin
            state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          // resp_data doubles as the line fill data, so stores park wdata here too.
          if (mem_resp_valid) begin
            resp_data <= req_write ? req_wdata : mem_resp_rdata;
            state     <= FILL;
          end
        end
        FILL: state <= RESP;
        RESP: begin
          last_rdata <= resp_data;
          state      <= IDLE;
        end
        default: state <= FLUSH;
      endcase

      if (flush_req && (state != IDLE) && (state != FLUSH)) pending_flush <= 1'b1;
    end
  end

  always_comb begin
    cache_write    = 1'b0;
    cache_valid_in = 1'b0;
    cache_wdata    = '0;
    cache_addr     = req_addr;
    if (state == FLUSH) begin
      cache_write = 1'b1;
      cache_addr  = {{(ADDR_WIDTH-SET_BIT_WIDTH){1'b0}}, sweep_cnt};
    end else if (state == FILL) begin
      cache_write    = 1'b1;
      cache_valid_in = 1'b1;
      cache_wdata    = resp_data;
    end
  end

  assign mem_req_valid  = (state == MEM_REQ);
  assign mem_req_write  = req_write;
  assign mem_req_addr   = req_addr;
  assign mem_req_wdata  = req_wdata;

  assign cpu_resp_valid = (state == RESP);
  assign cpu_resp_rdata = (state == RESP) ? resp_data : last_rdata;
  assign flush_busy     = (state == FLUSH);
  assign fsm_state      = state;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: models the cache array and a delayed memory, and
// scoreboards CPU responses against a reference memory image.
`timescale 1ns/1ps
module tb_cache_ctrl_fsm;
  localparam int SBW   = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NSETS = 4;
  localparam logic [2:0] ST_MEM_REQ  = 3'd3;
  localparam logic [2:0] ST_MEM_WAIT = 3'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_req_wdata;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_rdata;
  logic          flush_req, flush_busy;
  logic          cache_write, cache_valid_in, cache_hit;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata, cache_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic [2:0]    fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int resp_count = 0;
  int exp_total = 0;
  int last_resp_cyc = 0;
  int mem_rd_xfers = 0;
  int mem_wr_xfers = 0;
  int stall_left = 0;
  int resp_delay = 3;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  logic [AW-SBW-1:0] tag_arr[NSETS];
  logic              valid_arr[NSETS];
  logic [DW-1:0]     data_arr[NSETS];
  logic [SBW-1:0]    cidx;

  cache_ctrl_fsm #(.SET_BIT_WIDTH(SBW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata), .flush_req(flush_req), .flush_busy(flush_busy),
    .cache_write(cache_write), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_valid_in(cache_valid_in), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // cache array: combinational lookup, write captured mid-cycle and applied at the edge
  assign cidx        = cache_addr[SBW-1:0];
  assign cache_hit   = valid_arr[cidx] && (tag_arr[cidx] == cache_addr[AW-1:SBW]);
  assign cache_rdata = data_arr[cidx];

  initial begin
    logic          w_en, w_vi;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;
    for (int i = 0; i < NSETS; i++) begin
      valid_arr[i] = 1'b1;
      tag_arr[i]   = AW'($urandom);
      data_arr[i]  = $urandom;
    end
    forever begin
      @(negedge clk);
      w_en = cache_write; w_vi = cache_valid_in; w_a = cache_addr; w_d = cache_wdata;
      @(posedge clk);
      if (w_en) begin
        valid_arr[w_a[SBW-1:0]] = w_vi;
        tag_arr[w_a[SBW-1:0]]   = w_a[AW-1:SBW];
        data_arr[w_a[SBW-1:0]]  = w_d;
      end
    end
  end

  // memory responder with programmable stall and response delay
  initial begin
    logic [AW-1:0] held_addr;
    logic          held_write;
    logic [DW-1:0] held_wdata, rd;
    logic          stalling;
    int            countdown;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    stalling = 1'b0; countdown = 0; rd = '0;
    held_addr = '0; held_write = 1'b0; held_wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; countdown = 0; stalling = 1'b0;
      end else begin
        mem_resp_valid = 1'b0;
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rd;
          end
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          if (stalling) begin
            check("mreq_addr_stable", mem_req_addr, held_addr);
            check("mreq_write_stable", mem_req_write, held_write);
            check("mreq_wdata_stable", mem_req_wdata, held_wdata);
          end
          held_addr = mem_req_addr; held_write = mem_req_write; held_wdata = mem_req_wdata;
          if (stall_left > 0) begin
            stall_left--;
            stalling = 1'b1;
          end else begin
            mem_req_ready = 1'b1;
            stalling = 1'b0;
            if (mem_req_write) begin
              mem_wr_xfers++;
              mem_model[mem_req_addr] = mem_req_wdata;
              rd = '0;
            end else begin
              mem_rd_xfers++;
              rd = mem_read(mem_req_addr);
            end
            countdown = resp_delay;
          end
        end else begin
          stalling = 1'b0;
        end
      end
    end
  end

  // scoreboard: every response pulse pops one expected word
  always @(negedge clk) begin
    if (!reset && cpu_resp_valid) begin
      resp_count++;
      last_resp_cyc = cyc;
      check("resp_seq", resp_count, exp_total);
      if (exp_q.size() > 0) check("resp_rdata", cpu_resp_rdata, exp_q.pop_front());
    end
  end

  // driver: issue one request, wait for its response, report accept-to-pulse cycles
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat);
    int n;
    int acc;
    int rc0;
    exp_q.push_back(wr ? d : mem_read(a));
    exp_total++;
    rc0 = resp_count;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = a; cpu_req_wdata = d;
    #1;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("req_accept", cpu_req_ready, 1'b1);
    acc = cyc;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_write = 1'($urandom); cpu_req_addr = $urandom;
    cpu_req_wdata = $urandom;
    #1;
    n = 0;
    while (resp_count == rc0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("resp_seen", resp_count != rc0, 1'b1);
    lat = last_resp_cyc - acc;
  endtask

  task automatic count_sweep(output int len);
    int n;
    n = 0;
    while (!flush_busy && n < 20) begin
      @(negedge clk); #1; n++;
    end
    len = 0;
    while (flush_busy && len < 20) begin
      check("sweep_addr", cache_addr, len);
      len++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int lat, r0, w0, len, n;
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0;
    cpu_req_wdata = '0; flush_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_flush_busy", flush_busy, 1'b1);
    check("rst_ready", cpu_req_ready, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_resp_valid", cpu_resp_valid, 1'b0);

    // reset release: 4-cycle invalidate sweep, then ready
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NSETS; i++) begin
      check("sweep_addr", cache_addr, i);
      check("sweep_write", cache_write, 1'b1);
      check("sweep_valid_in", cache_valid_in, 1'b0);
      check("sweep_busy", flush_busy, 1'b1);
      check("sweep_ready", cpu_req_ready, 1'b0);
      @(negedge clk); #1;
    end
    check("post_sweep_ready", cpu_req_ready, 1'b1);
    check("post_sweep_busy", flush_busy, 1'b0);
    for (int i = 0; i < NSETS; i++) check("line_invalid", valid_arr[i], 1'b0);

    // cold load miss then hit
    mem_model[32'h10] = 32'h0000_CAFE;
    resp_delay = 3;
    r0 = mem_rd_xfers;
    do_req(1'b0, 32'h10, '0, lat);
    check("cold_rd_xfers", mem_rd_xfers - r0, 1);
    check("fill_data", data_arr[0], 32'h0000_CAFE);
    check("fill_valid", valid_arr[0], 1'b1);
    r0 = mem_rd_xfers + mem_wr_xfers;
    do_req(1'b0, 32'h10, '0, lat);
    check("hit_latency", lat, 2);
    check("hit_no_mem", mem_rd_xfers + mem_wr_xfers - r0, 0);

    // store write-through, then load hits the allocated line
    w0 = mem_wr_xfers;
    do_req(1'b1, 32'h24, 32'h1234, lat);
    check("store_wr_xfers", mem_wr_xfers - w0, 1);
    check("store_mem_data", mem_read(32'h24), 32'h1234);
    r0 = mem_rd_xfers + mem_wr_xfers;
    do_req(1'b0, 32'h24, '0, lat);
    check("store_hit_no_mem", mem_rd_xfers + mem_wr_xfers - r0, 0);
    check("store_hit_latency", lat, 2);

    // memory backpressure for 5 cycles
    stall_left = 5;
    r0 = mem_rd_xfers;
    do_req(1'b0, 32'h48, '0, lat);
    check("stall_rd_xfers", mem_rd_xfers - r0, 1);

    // flush pulse during MEM_WAIT: miss completes, then sweep, then re-miss
    fork
      do_req(1'b0, 32'h31, '0, lat);
      begin
        n = 0;
        @(negedge clk); #1;
        while (fsm_state != ST_MEM_WAIT && n < 50) begin
          @(negedge clk); #1; n++;
        end
        check("reach_mem_wait", fsm_state, ST_MEM_WAIT);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
      end
    join
    count_sweep(len);
    check("flush_sweep_len", len, NSETS);
    r0 = mem_rd_xfers;
    do_req(1'b0, 32'h31, '0, lat);
    check("after_flush_miss", mem_rd_xfers - r0, 1);

    // reset while a miss sits in MEM_REQ
    stall_left = 50;
    r0 = resp_count;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 32'h54;
    #1;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    cpu_req_valid = 1'b0;
    #1;
    n = 0;
    while (fsm_state != ST_MEM_REQ && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("pre_rst_mem_valid", mem_req_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_mem_valid", mem_req_valid, 1'b0);
    check("rst_mid_busy", flush_busy, 1'b1);
    stall_left = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    count_sweep(len);
    check("rst_mid_sweep_len", len, NSETS);
    check("rst_mid_no_resp", resp_count, r0);

    // random mix of loads and stores over a small address pool
    for (int k = 0; k < 12; k++) begin
      rw = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 31));
      rdat = $urandom;
      resp_delay = $urandom_range(1, 4);
      stall_left = $urandom_range(0, 2);
      do_req(rw, ra, rdat, lat);
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
